// File: rtl/ram_dma_arbiter_pkg.sv
// Helpers shared by the RAM DMA arbiter and its ID FIFO.
package ram_dma_arbiter_pkg;
    // Increment v and wrap to 0 when it reaches n (modulo-n counter step).
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
    endfunction
endpackage

// File: rtl/top_pkg.sv
// Shared bus widths for the DMA/RAM fabric.
package top_pkg;
    localparam int unsigned AXI_AW = 32;
    localparam int unsigned AXI_DW = 32;
endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of host IDs for outstanding device requests; the head names
// the host that owns the next device response.
module arb_id_fifo
    import ram_dma_arbiter_pkg::*;
#(
    parameter int unsigned IdW   = 1,
    parameter int unsigned Depth = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_i,
    input  logic [IdW-1:0] id_i,
    input  logic           pop_i,
    output logic [IdW-1:0] head_o,
    output logic           full_o,
    output logic           empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [IdW-1:0]  mem [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr_q];

    // Storage holds data only, so it is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= id_i;
        end
    end

    // Pointers and occupancy; reset flushes every outstanding entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= PtrW'(wrap_inc(32'(wr_ptr_q), Depth));
            end
            if (do_pop) begin
                rd_ptr_q <= PtrW'(wrap_inc(32'(rd_ptr_q), Depth));
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/ram_dma_arbiter.sv
// Round-robin arbiter sharing one RAM req/gnt/rvalid port among several DMA
// hosts. Requests are muxed combinationally; in-order responses are routed
// back to their issuing host via an ID FIFO.
module ram_dma_arbiter
    import ram_dma_arbiter_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned AW             = top_pkg::AXI_AW,
    parameter int unsigned DW             = top_pkg::AXI_DW,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NrHosts-1:0]            host_req_i,
    output logic [NrHosts-1:0]            host_gnt_o,
    input  logic [NrHosts-1:0]            host_we_i,
    input  logic [NrHosts-1:0][DW/8-1:0]  host_be_i,
    input  logic [NrHosts-1:0][AW-1:0]    host_addr_i,
    input  logic [NrHosts-1:0][DW-1:0]    host_wdata_i,
    output logic [NrHosts-1:0]            host_rvalid_o,
    output logic [DW-1:0]                 host_rdata_o,
    output logic [NrHosts-1:0]            host_err_o,
    output logic                          dev_req_o,
    output logic                          dev_we_o,
    output logic [DW/8-1:0]               dev_be_o,
    output logic [AW-1:0]                 dev_addr_o,
    output logic [DW-1:0]                 dev_wdata_o,
    input  logic                          dev_gnt_i,
    input  logic                          dev_rvalid_i,
    input  logic [DW-1:0]                 dev_rdata_i,
    input  logic                          dev_err_i,
    output logic                          spurious_rsp_o
);
    localparam int unsigned IdxW = $clog2(NrHosts);

    logic [IdxW-1:0] rr_ptr_q;
    logic            lock_q;
    logic [IdxW-1:0] lock_idx_q;
    logic [IdxW-1:0] sel;
    logic [IdxW-1:0] idx;
    logic            found;
    logic            handshake;
    logic            rsp_vld;
    logic [IdxW-1:0] head;
    logic            fifo_full;
    logic            fifo_empty;

    // Pick the locked host, else the first requester at or after rr_ptr.
    // Held at host 0 during reset so the payload outputs follow host 0.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        if (lock_q) begin
            sel = lock_idx_q;
        end else begin
            for (int unsigned i = 0; i < NrHosts; i++) begin
                idx = IdxW'((32'(rr_ptr_q) + i) % NrHosts);
                if (!found && host_req_i[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end
        if (!rst_ni) begin
            sel = '0;
        end
    end

    assign dev_req_o   = rst_ni && (|host_req_i) && !fifo_full;
    assign handshake   = dev_req_o && dev_gnt_i;
    assign dev_we_o    = host_we_i[sel];
    assign dev_be_o    = host_be_i[sel];
    assign dev_addr_o  = host_addr_i[sel];
    assign dev_wdata_o = host_wdata_i[sel];

    assign rsp_vld      = rst_ni && dev_rvalid_i && !fifo_empty;
    assign host_rdata_o = dev_rdata_i;

    // Grant only the selected host on a handshake; route a response to the FIFO head.
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        if (handshake) begin
            host_gnt_o[sel] = 1'b1;
        end
        if (rsp_vld) begin
            host_rvalid_o[head] = 1'b1;
            host_err_o[head]    = dev_err_i;
        end
    end

    // Round-robin pointer moves past the host just granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (handshake) begin
            rr_ptr_q <= IdxW'(wrap_inc(32'(sel), NrHosts));
        end
    end

    // Freeze the mux on a stalled request so payload stays stable until granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (handshake) begin
            lock_q <= 1'b0;
        end else if (dev_req_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
        end
    end

    // Sticky record of a device response with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spurious_rsp_o <= 1'b0;
        end else if (dev_rvalid_i && fifo_empty) begin
            spurious_rsp_o <= 1'b1;
        end
    end

    arb_id_fifo #(
        .IdW   (IdxW),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .id_i    (sel),
        .pop_i   (rsp_vld),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
endmodule

// File: tb/tb_ram_dma_arbiter.sv
// Self-checking bench for ram_dma_arbiter: per-scenario tasks with a
// response scoreboard filled at grant time and drained on host_rvalid_o.
module tb_ram_dma_arbiter;
    localparam int unsigned NH = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MO = 2;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic [NH-1:0]            host_req_i;
    logic [NH-1:0]            host_gnt_o;
    logic [NH-1:0]            host_we_i;
    logic [NH-1:0][DW/8-1:0]  host_be_i;
    logic [NH-1:0][AW-1:0]    host_addr_i;
    logic [NH-1:0][DW-1:0]    host_wdata_i;
    logic [NH-1:0]            host_rvalid_o;
    logic [DW-1:0]            host_rdata_o;
    logic [NH-1:0]            host_err_o;
    logic                     dev_req_o;
    logic                     dev_we_o;
    logic [DW/8-1:0]          dev_be_o;
    logic [AW-1:0]            dev_addr_o;
    logic [DW-1:0]            dev_wdata_o;
    logic                     dev_gnt_i;
    logic                     dev_rvalid_i;
    logic [DW-1:0]            dev_rdata_i;
    logic                     dev_err_i;
    logic                     spurious_rsp_o;

    typedef struct packed {
        logic [NH-1:0] host_oh;
        logic [DW-1:0] data;
        logic [NH-1:0] err_oh;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk_i = ~clk_i;

    ram_dma_arbiter #(
        .NrHosts        (NH),
        .AW             (AW),
        .DW             (DW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .host_req_i     (host_req_i),
        .host_gnt_o     (host_gnt_o),
        .host_we_i      (host_we_i),
        .host_be_i      (host_be_i),
        .host_addr_i    (host_addr_i),
        .host_wdata_i   (host_wdata_i),
        .host_rvalid_o  (host_rvalid_o),
        .host_rdata_o   (host_rdata_o),
        .host_err_o     (host_err_o),
        .dev_req_o      (dev_req_o),
        .dev_we_o       (dev_we_o),
        .dev_be_o       (dev_be_o),
        .dev_addr_o     (dev_addr_o),
        .dev_wdata_o    (dev_wdata_o),
        .dev_gnt_i      (dev_gnt_i),
        .dev_rvalid_i   (dev_rvalid_i),
        .dev_rdata_i    (dev_rdata_i),
        .dev_err_i      (dev_err_i),
        .spurious_rsp_o (spurious_rsp_o)
    );

    task automatic next_cycle;
        @(posedge clk_i);
        #1;
    endtask

    task automatic sb_push(input logic [NH-1:0] h, input logic [DW-1:0] d, input logic [NH-1:0] err);
        exp_t e;
        e.host_oh = h;
        e.data    = d;
        e.err_oh  = err;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(output exp_t e);
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
    endtask

    task automatic idle_inputs;
        host_req_i   = '0;
        host_we_i    = '0;
        host_be_i    = '1;
        host_wdata_i = '0;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b0;
        dev_rdata_i  = '0;
        dev_err_i    = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_ni         = 1'b0;
        host_req_i     = 2'b11;
        host_addr_i[0] = 32'h0000_1111;
        host_addr_i[1] = 32'h0000_2222;
        dev_gnt_i      = 1'b1;
        dev_rvalid_i   = 1'b1;
        dev_err_i      = 1'b1;
        @(posedge clk_i);
        #2;
        n_cmp++;
        if ({dev_req_o, host_gnt_o, host_rvalid_o, host_err_o, spurious_rsp_o} !== 8'b0) begin
            n_mis++;
            $display("FAIL reset_outputs: got %b want %b",
                     {dev_req_o, host_gnt_o, host_rvalid_o, host_err_o, spurious_rsp_o}, 8'b0);
        end
        n_cmp++;
        if (dev_addr_o !== 32'h0000_1111) begin
            n_mis++;
            $display("FAIL reset_payload: got %h want %h", dev_addr_o, 32'h0000_1111);
        end
        do_reset();
    endtask

    task automatic test_fairness;
        logic [NH-1:0] exp_h;
        exp_t          e;
        do_reset();
        host_addr_i[0] = 32'h0000_0100;
        host_addr_i[1] = 32'h0000_0200;
        host_req_i     = 2'b11;
        dev_gnt_i      = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) host_req_i = 2'b00;
            dev_rvalid_i = (k > 0);
            dev_rdata_i  = 32'hD000 + 32'(k) - 32'd1;
            #1;
            if (k > 0) begin
                sb_pop(e);
                n_cmp++;
                if ({host_rvalid_o, host_rdata_o, host_err_o} !== {e.host_oh, e.data, e.err_oh}) begin
                    n_mis++;
                    $display("FAIL fair_rsp k=%0d: got %h want %h", k,
                             {host_rvalid_o, host_rdata_o, host_err_o}, {e.host_oh, e.data, e.err_oh});
                end
            end
            if (k < 6) begin
                exp_h = NH'(1) << (k % 2);
                n_cmp++;
                if ({dev_req_o, host_gnt_o, dev_addr_o} !== {1'b1, exp_h, host_addr_i[k % 2]}) begin
                    n_mis++;
                    $display("FAIL fair_grant k=%0d: got %h want %h", k,
                             {dev_req_o, host_gnt_o, dev_addr_o}, {1'b1, exp_h, host_addr_i[k % 2]});
                end
                sb_push(exp_h, 32'hD000 + 32'(k), '0);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_lock;
        logic [NH-1:0] exp_g;
        exp_t          e;
        do_reset();
        host_addr_i[0] = 32'h0020_0000;
        host_addr_i[1] = 32'h0010_0010;
        host_req_i     = 2'b10;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) host_req_i = 2'b11;
            if (k == 4) host_req_i = 2'b01;
            dev_gnt_i    = (k >= 3);
            dev_rvalid_i = (k == 4);
            dev_rdata_i  = 32'hBEEF_0001;
            #1;
            if (k <= 3) begin
                exp_g = (k == 3) ? 2'b10 : 2'b00;
                n_cmp++;
                if ({dev_req_o, dev_addr_o, host_gnt_o} !== {1'b1, 32'h0010_0010, exp_g}) begin
                    n_mis++;
                    $display("FAIL lock_hold k=%0d: got %h want %h", k,
                             {dev_req_o, dev_addr_o, host_gnt_o}, {1'b1, 32'h0010_0010, exp_g});
                end
                if (k == 3) sb_push(2'b10, 32'hBEEF_0001, '0);
            end else begin
                sb_pop(e);
                n_cmp++;
                if ({host_rvalid_o, host_rdata_o, host_err_o} !== {e.host_oh, e.data, e.err_oh}) begin
                    n_mis++;
                    $display("FAIL lock_rsp: got %h want %h",
                             {host_rvalid_o, host_rdata_o, host_err_o}, {e.host_oh, e.data, e.err_oh});
                end
                n_cmp++;
                if ({dev_addr_o, host_gnt_o} !== {32'h0020_0000, 2'b01}) begin
                    n_mis++;
                    $display("FAIL lock_next: got %h want %h", {dev_addr_o, host_gnt_o}, {32'h0020_0000, 2'b01});
                end
                sb_push(2'b01, 32'hBEEF_0002, '0);
            end
            next_cycle();
        end
        host_req_i   = 2'b00;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'hBEEF_0002;
        #1;
        sb_pop(e);
        n_cmp++;
        if ({host_rvalid_o, host_rdata_o, host_err_o} !== {e.host_oh, e.data, e.err_oh}) begin
            n_mis++;
            $display("FAIL lock_rsp2: got %h want %h",
                     {host_rvalid_o, host_rdata_o, host_err_o}, {e.host_oh, e.data, e.err_oh});
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_full;
        exp_t e;
        do_reset();
        host_addr_i[0] = 32'h0000_0300;
        host_addr_i[1] = 32'h0000_0400;
        host_req_i     = 2'b11;
        dev_gnt_i      = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++;
            if (host_gnt_o !== (NH'(1) << k)) begin
                n_mis++;
                $display("FAIL full_fill k=%0d: got %b want %b", k, host_gnt_o, NH'(1) << k);
            end
            sb_push(NH'(1) << k, 32'hF000 + 32'(k), '0);
            next_cycle();
        end
        #1;
        n_cmp++;
        if ({dev_req_o, host_gnt_o, host_rvalid_o} !== 5'b0) begin
            n_mis++;
            $display("FAIL full_stall: got %b want %b", {dev_req_o, host_gnt_o, host_rvalid_o}, 5'b0);
        end
        next_cycle();
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'hF000;
        #1;
        n_cmp++;
        if ({dev_req_o, host_gnt_o} !== 3'b0) begin
            n_mis++;
            $display("FAIL full_no_bypass: got %b want %b", {dev_req_o, host_gnt_o}, 3'b0);
        end
        sb_pop(e);
        n_cmp++;
        if ({host_rvalid_o, host_rdata_o, host_err_o} !== {e.host_oh, e.data, e.err_oh}) begin
            n_mis++;
            $display("FAIL full_rsp0: got %h want %h",
                     {host_rvalid_o, host_rdata_o, host_err_o}, {e.host_oh, e.data, e.err_oh});
        end
        next_cycle();
        dev_rvalid_i = 1'b0;
        #1;
        n_cmp++;
        if ({dev_req_o, host_gnt_o} !== 3'b101) begin
            n_mis++;
            $display("FAIL full_regrant: got %b want %b", {dev_req_o, host_gnt_o}, 3'b101);
        end
        sb_push(2'b01, 32'hF002, '0);
        next_cycle();
        host_req_i = 2'b00;
        for (int k = 1; k < 3; k++) begin
            dev_rvalid_i = 1'b1;
            dev_rdata_i  = 32'hF000 + 32'(k);
            #1;
            sb_pop(e);
            n_cmp++;
            if ({host_rvalid_o, host_rdata_o, host_err_o} !== {e.host_oh, e.data, e.err_oh}) begin
                n_mis++;
                $display("FAIL full_drain k=%0d: got %h want %h", k,
                         {host_rvalid_o, host_rdata_o, host_err_o}, {e.host_oh, e.data, e.err_oh});
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_routing;
        logic [NH-1:0] req_seq [5];
        logic [NH-1:0] gnt_seq [5];
        logic          rv_seq  [5];
        logic [DW-1:0] dat_seq [5];
        logic          err_seq [5];
        exp_t          e;
        req_seq = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b00};
        gnt_seq = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
        rv_seq  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        dat_seq = '{32'h0, 32'h0, 32'hA, 32'hB, 32'hC};
        err_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        host_addr_i[0] = 32'h0000_0500;
        host_addr_i[1] = 32'h0000_0600;
        dev_gnt_i      = 1'b1;
        sb_push(2'b10, 32'hA, 2'b00);
        sb_push(2'b01, 32'hB, 2'b01);
        sb_push(2'b10, 32'hC, 2'b00);
        for (int k = 0; k < 5; k++) begin
            host_req_i   = req_seq[k];
            dev_rvalid_i = rv_seq[k];
            dev_rdata_i  = dat_seq[k];
            dev_err_i    = err_seq[k];
            #1;
            n_cmp++;
            if (host_gnt_o !== gnt_seq[k]) begin
                n_mis++;
                $display("FAIL route_grant k=%0d: got %b want %b", k, host_gnt_o, gnt_seq[k]);
            end
            if (rv_seq[k]) begin
                sb_pop(e);
                n_cmp++;
                if ({host_rvalid_o, host_rdata_o, host_err_o} !== {e.host_oh, e.data, e.err_oh}) begin
                    n_mis++;
                    $display("FAIL route_rsp k=%0d: got %h want %h", k,
                             {host_rvalid_o, host_rdata_o, host_err_o}, {e.host_oh, e.data, e.err_oh});
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_spurious;
        do_reset();
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'h5555_AAAA;
        #1;
        n_cmp++;
        if ({host_rvalid_o, spurious_rsp_o} !== 3'b000) begin
            n_mis++;
            $display("FAIL spur_drop: got %b want %b", {host_rvalid_o, spurious_rsp_o}, 3'b000);
        end
        next_cycle();
        dev_rvalid_i = 1'b0;
        #1;
        n_cmp++;
        if (spurious_rsp_o !== 1'b1) begin
            n_mis++;
            $display("FAIL spur_set: got %b want %b", spurious_rsp_o, 1'b1);
        end
        repeat (3) next_cycle();
        n_cmp++;
        if (spurious_rsp_o !== 1'b1) begin
            n_mis++;
            $display("FAIL spur_sticky: got %b want %b", spurious_rsp_o, 1'b1);
        end
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (spurious_rsp_o !== 1'b0) begin
            n_mis++;
            $display("FAIL spur_reset: got %b want %b", spurious_rsp_o, 1'b0);
        end
        do_reset();
    endtask

    task automatic test_reset_mid;
        do_reset();
        host_addr_i[0] = 32'h0000_0700;
        host_addr_i[1] = 32'h0000_0800;
        host_req_i     = 2'b01;
        dev_gnt_i      = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++;
            if (host_gnt_o !== 2'b01) begin
                n_mis++;
                $display("FAIL mid_fill k=%0d: got %b want %b", k, host_gnt_o, 2'b01);
            end
            next_cycle();
        end
        host_req_i   = 2'b11;
        dev_rvalid_i = 1'b1;
        dev_err_i    = 1'b1;
        rst_ni       = 1'b0;
        #1;
        n_cmp++;
        if ({dev_req_o, host_gnt_o, host_rvalid_o, host_err_o, spurious_rsp_o, dev_addr_o} !==
            {8'b0, 32'h0000_0700}) begin
            n_mis++;
            $display("FAIL mid_reset_out: got %h want %h",
                     {dev_req_o, host_gnt_o, host_rvalid_o, host_err_o, spurious_rsp_o, dev_addr_o},
                     {8'b0, 32'h0000_0700});
        end
        next_cycle();
        rst_ni     = 1'b1;
        exp_q.delete();
        host_req_i = 2'b00;
        dev_gnt_i  = 1'b0;
        dev_err_i  = 1'b0;
        #1;
        n_cmp++;
        if (host_rvalid_o !== 2'b00) begin
            n_mis++;
            $display("FAIL mid_stale_rsp: got %b want %b", host_rvalid_o, 2'b00);
        end
        next_cycle();
        dev_rvalid_i = 1'b0;
        host_req_i   = 2'b11;
        dev_gnt_i    = 1'b1;
        #1;
        n_cmp++;
        if ({spurious_rsp_o, host_gnt_o} !== 3'b101) begin
            n_mis++;
            $display("FAIL mid_spur_rr: got %b want %b", {spurious_rsp_o, host_gnt_o}, 3'b101);
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        rst_ni       = 1'b0;
        host_addr_i  = '0;
        idle_inputs();
        test_reset();
        test_fairness();
        test_lock();
        test_full();
        test_routing();
        test_spurious();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL sb_leftover: got %0d want %0d", exp_q.size(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
